// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences an external 4-bit universal shift register.
// A command is captured in IDLE, the register is parallel-loaded for one
// cycle, shifted for the saturated count (0..4) of cycles, then a one-cycle
// done pulse is emitted. Outputs other than cmd_ready are registered, so
// they follow the internal state by one cycle.
// Optional feature: define SHSEQ_ROTATE_EN to enable circular rotate, where
// the serial inputs are taken from the fed-back register contents.
module shift_sequencer (
  input  logic       clk,
  input  logic       clr,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_data,
  input  logic       cmd_dir,
  input  logic [2:0] cmd_count,
  input  logic       cmd_fill,
  input  logic       cmd_rot,
  input  logic [3:0] usr_out,
  output logic [3:0] parin,
  output logic [1:0] sel,
  output logic       sin_r,
  output logic       sin_l,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] SHIFT = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  logic [1:0] state;
  logic [2:0] remain;
  logic [3:0] data_q;
  logic       dir_q;
  logic       fill_q;
  logic       ready_q;
  logic [3:0] parin_q;
  logic [1:0] sel_q;
  logic       sin_r_q;
  logic       sin_l_q;
  logic       busy_q;
  logic       done_q;

  // Ready is held off until the first edge after reset release, and drops
  // combinationally the moment clr rises.
  assign cmd_ready = (state == IDLE) && ready_q && !clr;

  // Sequencing FSM: capture the command, load, count shifts, complete.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      remain  <= 3'd0;
      data_q  <= 4'b0000;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            data_q <= cmd_data;
            dir_q  <= cmd_dir;
            fill_q <= cmd_fill;
            remain <= (cmd_count > 3'd4) ? 3'd4 : cmd_count;
            state  <= LOAD;
          end
        end
        LOAD:    state <= (remain == 3'd0) ? DONE : SHIFT;
        SHIFT: begin
          remain <= remain - 3'd1;
          if (remain == 3'd1) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output registers decoded from the current state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sel_q   <= SEL_HOLD;
      parin_q <= 4'b0000;
      sin_r_q <= 1'b0;
      sin_l_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      parin_q <= data_q;
      sin_r_q <= fill_q;
      sin_l_q <= fill_q;
      busy_q  <= (state != IDLE);
      done_q  <= (state == DONE);
      case (state)
        LOAD:    sel_q <= SEL_LOAD;
        SHIFT:   sel_q <= dir_q ? SEL_LEFT : SEL_RIGHT;
        default: sel_q <= SEL_HOLD;
      endcase
    end
  end

  assign parin = parin_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef SHSEQ_ROTATE_EN
  logic rot_q;

  // Rotate flag captured alongside the other command fields.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                             rot_q <= 1'b0;
    else if (state == IDLE && cmd_valid && cmd_ready)    rot_q <= cmd_rot;
  end

  // While rotating, the serial inputs must track the register bits shifting
  // out on every cycle, so they come straight from the feedback bus.
  assign sin_r = (rot_q && (sel_q == SEL_RIGHT || sel_q == SEL_LEFT)) ? usr_out[0] : sin_r_q;
  assign sin_l = (rot_q && (sel_q == SEL_RIGHT || sel_q == SEL_LEFT)) ? usr_out[3] : sin_l_q;
`else
  logic unused_rot;
  assign unused_rot = ^{cmd_rot, usr_out};
  assign sin_r = sin_r_q;
  assign sin_l = sin_l_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer. A behavioural 4-bit universal
// shift register closes the usr_out feedback loop.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_data = 4'b0000;
  logic       cmd_dir = 1'b0;
  logic [2:0] cmd_count = 3'd0;
  logic       cmd_fill = 1'b0;
  logic       cmd_rot = 1'b0;
  logic [3:0] usr_out;
  logic [3:0] parin;
  logic [1:0] sel;
  logic       sin_r;
  logic       sin_l;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  shift_sequencer dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .cmd_fill(cmd_fill), .cmd_rot(cmd_rot), .usr_out(usr_out),
    .parin(parin), .sel(sel), .sin_r(sin_r), .sin_l(sin_l),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External universal shift register driven by the sequencer.
  logic [3:0] shreg = 4'b0000;
  always @(posedge clk) begin
    case (sel)
      2'b01:   shreg <= {sin_r, shreg[3:1]};
      2'b10:   shreg <= {shreg[2:0], sin_l};
      2'b11:   shreg <= parin;
      default: shreg <= shreg;
    endcase
  end
  assign usr_out = shreg;

  // Offers one command, then checks every output cycle up to one past done.
  task automatic run_seq(input string name, input logic [3:0] data, input logic dir,
                         input logic [2:0] count, input logic fill, input logic rot,
                         input logic [3:0] exp_reg);
    int n;
    int waited;
    logic [1:0] exp_sel;
    n = (count > 3'd4) ? 4 : int'(count);
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_timeout got=%b want=1", name, cmd_ready);
    end
    cmd_data = data; cmd_dir = dir; cmd_count = count; cmd_fill = fill; cmd_rot = rot;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= n + 3; k++) begin
      @(posedge clk); #1;
      if (k == 1)            exp_sel = 2'b11;
      else if (k <= n + 1)   exp_sel = dir ? 2'b10 : 2'b01;
      else                   exp_sel = 2'b00;
      checks++;
      if (sel !== exp_sel || done !== (k == n + 2) || busy !== (k <= n + 2)) begin
        failures++;
        $display("FAIL %s cycle%0d sel/done/busy got=%b/%b/%b want=%b/%b/%b", name, k,
                 sel, done, busy, exp_sel, (k == n + 2), (k <= n + 2));
      end
      if (k == 1) begin
        checks++;
        if (parin !== data) begin
          failures++;
          $display("FAIL %s parin got=%b want=%b", name, parin, data);
        end
      end
      if (!rot && k >= 2 && k <= n + 1) begin
        checks++;
        if (sin_r !== fill || sin_l !== fill) begin
          failures++;
          $display("FAIL %s sin cycle%0d got=%b%b want=%b%b", name, k, sin_r, sin_l, fill, fill);
        end
      end
      if (k == n + 2) begin
        checks++;
        if (shreg !== exp_reg) begin
          failures++;
          $display("FAIL %s register got=%b want=%b", name, shreg, exp_reg);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s ready_in_done_cycle got=%b want=1", name, cmd_ready);
        end
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sel, parin, sin_r, sin_l, busy, done, cmd_ready} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {sel, parin, sin_r, sin_l, busy, done, cmd_ready});
    end
    clr = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_before_edge got=%b want=0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_after_edge got=%b/%b want=1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_shift_right();
    run_seq("right_cnt2", 4'b1011, 1'b0, 3'd2, 1'b0, 1'b0, 4'b0010);
  endtask

  task automatic test_shift_left_saturate();
    run_seq("left_cnt7", 4'b1011, 1'b1, 3'd7, 1'b1, 1'b0, 4'b1111);
  endtask

  task automatic test_count_zero();
    run_seq("cnt0", 4'b0110, 1'b0, 3'd0, 1'b1, 1'b0, 4'b0110);
  endtask

  task automatic test_rot_ignored();
`ifdef SHSEQ_ROTATE_EN
    run_seq("rotate_cnt1", 4'b1011, 1'b0, 3'd1, 1'b0, 1'b1, 4'b1101);
`else
    run_seq("rot_ignored_cnt1", 4'b1011, 1'b0, 3'd1, 1'b0, 1'b1, 4'b0101);
`endif
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_first", 4'b0001, 1'b1, 3'd1, 1'b0, 1'b0, 4'b0010);
    // The done cycle has ready high, so run_seq accepts on the very next edge.
    run_seq("b2b_second", 4'b1000, 1'b0, 3'd3, 1'b1, 1'b0, 4'b1111);
  endtask

  task automatic test_ignore_busy();
    run_seq("pre_ignore", 4'b0100, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0100);
    cmd_data = 4'b0011; cmd_dir = 1'b0; cmd_count = 3'd1; cmd_fill = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Offer a second command while the first is in flight.
    cmd_data = 4'b1111; cmd_dir = 1'b1; cmd_count = 3'd4;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL ignore_ready_busy got=%b want=0", cmd_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || shreg !== 4'b0001) begin
      failures++;
      $display("FAIL ignore_first_done got=%b/%b want=1/0001", done, shreg);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || sel !== 2'b00) begin
        failures++;
        $display("FAIL ignore_no_queue cycle%0d busy/sel got=%b/%b want=0/00", k, busy, sel);
      end
    end
  endtask

  task automatic test_abort();
    int seen_done;
    cmd_data = 4'b1001; cmd_dir = 1'b0; cmd_count = 3'd3; cmd_fill = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (sel !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_second_shift got=%b/%b want=01/1", sel, busy);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (sel !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0 || parin !== 4'b0000) begin
      failures++;
      $display("FAIL abort_immediate sel/busy/done/ready/parin got=%b/%b/%b/%b/%b want=00/0/0/0/0000",
               sel, busy, done, cmd_ready, parin);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d want=0", seen_done);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready_after got=%b want=1", cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_shift_right();
    test_shift_left_saturate();
    test_count_zero();
    test_rot_ignored();
    test_back_to_back();
    test_ignore_busy();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port clr  input  1  asynchronous active-high reset.
REQ-003 SHALL have port cmd_valid  input  1  command offered.
REQ-004 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-005 SHALL have port cmd_data  input  4  word to load.
REQ-006 SHALL have port cmd_dir  input  1  0 = shift right, 1 = shift left.
REQ-007 SHALL have port cmd_count  input  3  number of shift cycles requested.
REQ-008 SHALL have port cmd_fill  input  1  serial fill bit.
REQ-009 SHALL have port cmd_rot  input  1  rotate request.
REQ-010 SHALL have port usr_out  input  4  current shift-register contents fed back.
REQ-011 SHALL have port parin  output  4  parallel data to the shift register.
REQ-012 SHALL have port sel  output  2  mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-013 SHALL have port sin_r  output  1  serial input entering bit 3 on shift right.
REQ-014 SHALL have port sin_l  output  1  serial input entering bit 0 on shift left.
REQ-015 SHALL have port busy  output  1  sequence in progress.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, LOAD, SHIFT, DONE, with all outputs except cmd_ready registered.
REQ-018 SHALL drive cmd_ready = 1 only in IDLE with clr low; in IDLE, cmd_valid & cmd_ready captures all cmd_* fields and moves to LOAD.
REQ-019 SHALL, in LOAD (one cycle), drive sel = 11 and parin = captured cmd_data.
REQ-020 SHALL saturate the captured count: values 5..7 are treated as 4.
REQ-021 SHALL, with count 0, go LOAD -> DONE, and with count N = 1..4, spend exactly N SHIFT cycles.
REQ-022 SHALL, in SHIFT, drive sel = 01 when cmd_dir = 0 and 10 when cmd_dir = 1.
REQ-023 SHALL hold parin at the captured value outside LOAD.
REQ-024 SHALL, in non-rotate mode, drive sin_r = sin_l = captured cmd_fill.
REQ-025 SHALL, in DONE (one cycle), drive sel = 00 and done = 1, then return to IDLE.
REQ-026 SHALL drive busy = 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-027 SHALL drive sel = 00 in IDLE.
REQ-028 SHALL ignore cmd_valid while not in IDLE; no command is queued.
REQ-029 SHALL give latency from the accept edge to the done pulse of N+2 cycles.
REQ-030 SHALL allow back-to-back commands: the next command is accepted the cycle after DONE.

Reset
REQ-031 SHALL, on clr high, immediately force: state IDLE, sel = 00, parin = 0000, sin_r = 0, sin_l = 0, busy = 0, done = 0, cmd_ready = 0.
REQ-032 SHALL, on clr mid-sequence, abort it without emitting a done pulse.
REQ-033 SHALL raise cmd_ready on the first clk edge after clr deasserts.

Configuration
REQ-034 SHALL, with SHSEQ_ROTATE_EN defined and captured cmd_rot = 1, drive during SHIFT sin_r = usr_out[0] and sin_l = usr_out[3], giving a circular rotate.
REQ-035 SHALL, without SHSEQ_ROTATE_EN, ignore cmd_rot and usr_out and always use cmd_fill.

Verification
REQ-036 SHALL check: clr high then low -> all outputs 0, then cmd_ready = 1 at the next edge.
REQ-037 SHALL check: cmd_data = 1011, cmd_dir = 0, cmd_count = 2, cmd_fill = 0 -> sel sequence 11, 01, 01, 00; done one cycle; register holds 0010.
REQ-038 SHALL check: cmd_data = 1011, cmd_dir = 1, cmd_count = 7, cmd_fill = 1 -> four 10 cycles, register holds 1111, done at accept + 6.
REQ-039 SHALL check: cmd_count = 0 -> sel 11 then 00, done at accept + 2.
REQ-040 SHALL check: clr asserted during second SHIFT -> sel = 00 and busy = 0 immediately, no done pulse.
REQ-041 SHALL check: with SHSEQ_ROTATE_EN, cmd_data = 1011, cmd_dir = 0, cmd_rot = 1, cmd_count = 1 -> register holds 1101.
